// File: rtl/midi_message_parser.sv
// MIDI byte-stream parser: running status, SysEx skipping and real-time interleaving,
// emitting note/control/bend messages over a valid/ready handshake with sticky overflow.
module midi_message_parser #(
  parameter bit         OMNI    = 1'b1,
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic       clock_50_000_000,
  input  logic       reset_l,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       msg_valid,
  input  logic       msg_ready,
  output logic [1:0] msg_type,
  output logic [3:0] msg_channel,
  output logic [6:0] msg_data1,
  output logic [6:0] msg_data2,
  output logic       overflow
);

  typedef enum logic [1:0] {WAIT_STATUS, WAIT_DATA1, WAIT_DATA2, SYSEX} state_t;

  state_t     state;
  logic [7:0] run_status;
  logic [6:0] data1;

  logic       is_data, is_realtime, is_chan_status, one_byte;
  logic       complete, emit;
  logic [3:0] kind;
  logic [6:0] next_d1, next_d2;
  logic [1:0] next_type;

  always_comb begin
    is_data        = ~byte_in[7];
    is_realtime    = byte_in[7:3] == 5'b11111;
    is_chan_status = byte_in[7] && (byte_in[7:4] != 4'hF);
    kind           = run_status[7:4];
    one_byte       = (kind == 4'hC) || (kind == 4'hD);
    complete       = byte_valid && is_data &&
                     (((state == WAIT_DATA1) && one_byte) || (state == WAIT_DATA2));
    next_d1        = (state == WAIT_DATA2) ? data1 : byte_in[6:0];
    next_d2        = (state == WAIT_DATA2) ? byte_in[6:0] : '0;
    next_type      = 2'd0;
    emit           = 1'b0;
    case (kind)
      4'h8: begin next_type = 2'd1; emit = complete; end
      // Zero-velocity note-on is the common running-status form of note-off.
      4'h9: begin next_type = (next_d2 == '0) ? 2'd1 : 2'd0; emit = complete; end
      4'hB: begin next_type = 2'd2; emit = complete; end
      4'hE: begin next_type = 2'd3; emit = complete; end
      default: ;
    endcase
    if (!OMNI && (run_status[3:0] != CHANNEL)) emit = 1'b0;
  end

  always_ff @(posedge clock_50_000_000) begin
    if (!reset_l) begin
      state       <= WAIT_STATUS;
      run_status  <= '0;
      data1       <= '0;
      msg_valid   <= 1'b0;
      msg_type    <= '0;
      msg_channel <= '0;
      msg_data1   <= '0;
      msg_data2   <= '0;
      overflow    <= 1'b0;
    end else begin
      if (byte_valid && !is_realtime) begin
        if (is_chan_status) begin
          run_status <= byte_in;
          data1      <= '0;
          state      <= WAIT_DATA1;
        end else if (byte_in == 8'hF0) begin
          run_status <= '0;
          state      <= SYSEX;
        end else if (byte_in[7]) begin
          run_status <= '0;
          state      <= WAIT_STATUS;
        end else begin
          case (state)
            WAIT_DATA1: begin
              data1 <= byte_in[6:0];
              state <= one_byte ? WAIT_DATA1 : WAIT_DATA2;
            end
            WAIT_DATA2: state <= WAIT_DATA1;
            default: ;
          endcase
        end
      end

      if (emit && (!msg_valid || msg_ready)) begin
        msg_valid   <= 1'b1;
        msg_type    <= next_type;
        msg_channel <= run_status[3:0];
        msg_data1   <= next_d1;
        msg_data2   <= next_d2;
      end else begin
        if (emit) overflow <= 1'b1;
        if (msg_valid && msg_ready) begin
          msg_valid   <= 1'b0;
          msg_type    <= '0;
          msg_channel <= '0;
          msg_data1   <= '0;
          msg_data2   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_message_parser.sv
// Directed bench for midi_message_parser: a table of byte/expected-output records plus
// hand-written handshake, overflow, reset and channel-filter sequences.
module tb_midi_message_parser;

  logic       clk = 1'b0;
  logic       reset_l, byte_valid, msg_ready;
  logic [7:0] byte_in;

  logic       m_valid, m_ovf, f_valid, f_ovf;
  logic [1:0] m_type, f_type;
  logic [3:0] m_ch, f_ch;
  logic [6:0] m_d1, m_d2, f_d1, f_d2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  midi_message_parser dut (
    .clock_50_000_000(clk), .reset_l(reset_l), .byte_in(byte_in), .byte_valid(byte_valid),
    .msg_valid(m_valid), .msg_ready(msg_ready), .msg_type(m_type), .msg_channel(m_ch),
    .msg_data1(m_d1), .msg_data2(m_d2), .overflow(m_ovf)
  );

  midi_message_parser #(.OMNI(1'b0), .CHANNEL(4'd2)) dut_f (
    .clock_50_000_000(clk), .reset_l(reset_l), .byte_in(byte_in), .byte_valid(byte_valid),
    .msg_valid(f_valid), .msg_ready(msg_ready), .msg_type(f_type), .msg_channel(f_ch),
    .msg_data1(f_d1), .msg_data2(f_d2), .overflow(f_ovf)
  );

  typedef struct {
    logic [7:0] b;
    bit         rdy;
    bit         v;
    logic [1:0] t;
    logic [3:0] ch;
    logic [6:0] d1;
    logic [6:0] d2;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [7:0] b, input bit v, input logic [1:0] t,
                     input logic [3:0] ch, input logic [6:0] d1, input logic [6:0] d2);
    vec_t x;
    x.b = b; x.rdy = 1'b1; x.v = v; x.t = t; x.ch = ch; x.d1 = d1; x.d2 = d2;
    vecs.push_back(x);
  endtask

  task automatic send(input logic [7:0] b, input bit r);
    @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    msg_ready  = r;
    @(posedge clk);
    #1 byte_valid = 1'b0;
  endtask

  task automatic idle(input bit r);
    @(negedge clk);
    msg_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_l = 1'b0;
    @(posedge clk);
    #1 reset_l = 1'b1;
  endtask

  task automatic check(input string name, input bit filt, input bit v, input logic [1:0] t,
                       input logic [3:0] ch, input logic [6:0] d1, input logic [6:0] d2,
                       input bit ovf);
    logic [21:0] act, exp;
    act = filt ? {f_valid, f_type, f_ch, f_d1, f_d2, f_ovf}
               : {m_valid, m_type, m_ch, m_d1, m_d2, m_ovf};
    exp = {v, t, ch, d1, d2, ovf};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got v/t/ch/d1/d2/ovf=%h required %h", name, act, exp);
    end
  endtask

  initial begin
    reset_l    = 1'b0;
    byte_valid = 1'b0;
    msg_ready  = 1'b1;
    byte_in    = '0;

    add(8'h90, 0, 0, 0, 0, 0);  add(8'h3C, 0, 0, 0, 0, 0);  add(8'h64, 1, 0, 0, 7'h3C, 7'h64);
    add(8'h91, 0, 0, 0, 0, 0);  add(8'h40, 0, 0, 0, 0, 0);  add(8'h7F, 1, 0, 1, 7'h40, 7'h7F);
    add(8'h40, 0, 0, 0, 0, 0);  add(8'h00, 1, 1, 1, 7'h40, 7'h00);
    add(8'h90, 0, 0, 0, 0, 0);  add(8'h3C, 0, 0, 0, 0, 0);  add(8'hF8, 0, 0, 0, 0, 0);
    add(8'h64, 1, 0, 0, 7'h3C, 7'h64);
    add(8'hF0, 0, 0, 0, 0, 0);  add(8'h01, 0, 0, 0, 0, 0);  add(8'h02, 0, 0, 0, 0, 0);
    add(8'hF7, 0, 0, 0, 0, 0);  add(8'h3C, 0, 0, 0, 0, 0);  add(8'h64, 0, 0, 0, 0, 0);
    add(8'hE5, 0, 0, 0, 0, 0);  add(8'h00, 0, 0, 0, 0, 0);  add(8'h40, 1, 3, 5, 7'h00, 7'h40);
    add(8'hB3, 0, 0, 0, 0, 0);  add(8'h07, 0, 0, 0, 0, 0);  add(8'h64, 1, 2, 3, 7'h07, 7'h64);
    add(8'hC0, 0, 0, 0, 0, 0);  add(8'h05, 0, 0, 0, 0, 0);  add(8'h06, 0, 0, 0, 0, 0);
    add(8'hA0, 0, 0, 0, 0, 0);  add(8'h3C, 0, 0, 0, 0, 0);  add(8'h64, 0, 0, 0, 0, 0);
    add(8'h90, 0, 0, 0, 0, 0);  add(8'h3C, 0, 0, 0, 0, 0);  add(8'h80, 0, 0, 0, 0, 0);
    add(8'h3C, 0, 0, 0, 0, 0);  add(8'h00, 1, 1, 0, 7'h3C, 7'h00);
    add(8'hF1, 0, 0, 0, 0, 0);  add(8'h3C, 0, 0, 0, 0, 0);  add(8'h64, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1 reset_l = 1'b1;
    check("reset", 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i].b, vecs[i].rdy);
      check($sformatf("vec%0d_byte_%h", i, vecs[i].b), 0,
            vecs[i].v, vecs[i].t, vecs[i].ch, vecs[i].d1, vecs[i].d2, 0);
    end

    // Hold a message, then accept it in the same cycle a new one completes.
    send(8'h90, 0); send(8'h3C, 0); send(8'h64, 0);
    check("held_note_on", 0, 1, 0, 0, 7'h3C, 7'h64, 0);
    send(8'h3C, 0);
    check("held_stable", 0, 1, 0, 0, 7'h3C, 7'h64, 0);
    send(8'h65, 1);
    check("accept_and_complete", 0, 1, 0, 0, 7'h3C, 7'h65, 0);
    idle(1);
    check("drained", 0, 0, 0, 0, 0, 0, 0);

    // Completion while held and not accepted: dropped, overflow sticks.
    send(8'hB0, 0); send(8'h07, 0); send(8'h64, 0);
    check("control_held", 0, 1, 2, 0, 7'h07, 7'h64, 0);
    send(8'hE0, 0); send(8'h00, 0); send(8'h40, 0);
    check("bend_dropped", 0, 1, 2, 0, 7'h07, 7'h64, 1);
    idle(1);
    check("overflow_sticky", 0, 0, 0, 0, 0, 0, 1);

    // Reset mid-frame discards running status.
    do_reset();
    check("reset_clears_ovf", 0, 0, 0, 0, 0, 0, 0);
    send(8'h90, 1); send(8'h3C, 1);
    do_reset();
    send(8'h64, 1);
    check("reset_midframe", 0, 0, 0, 0, 0, 0, 0);
    send(8'h3C, 1); send(8'h64, 1);
    check("no_running_status", 0, 0, 0, 0, 0, 0, 0);

    // Channel filter instance (OMNI=0, CHANNEL=2).
    send(8'h93, 1); send(8'h3C, 1); send(8'h64, 1);
    check("filter_ch3_blocked", 1, 0, 0, 0, 0, 0, 0);
    check("omni_ch3_passed", 0, 1, 0, 3, 7'h3C, 7'h64, 0);
    send(8'h92, 1); send(8'h3C, 1); send(8'h64, 1);
    check("filter_ch2_passed", 1, 1, 0, 2, 7'h3C, 7'h64, 0);
    send(8'hC0, 1); send(8'h05, 1);
    check("filter_prog_change", 1, 0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
